// File: rtl/execute_stage.sv
// Y86-64 execute stage: D/E register, operand select, ALU, condition codes,
// branch/cmov evaluation and E/M register. e_valE/e_dstE feed decode forwarding.

module ALU (
  input  logic signed [63:0] in1,
  input  logic signed [63:0] in2,
  input  logic        [1:0]  control,
  output logic signed [63:0] out,
  output logic               of
);
  always_comb begin
    out = '0;
    of  = 1'b0;
    case (control)
      2'b00: begin
        out = in1 + in2;
        of  = (in1[63] == in2[63]) && (out[63] != in1[63]);
      end
      2'b01: begin
        out = in1 - in2;
        of  = (in1[63] != in2[63]) && (out[63] != in1[63]);
      end
      2'b10: out = in1 & in2;
      default: out = in1 ^ in2;
    endcase
  end
endmodule

module execute_stage #(
  parameter logic [3:0] RNONE  = 4'hF,
  parameter logic [2:0] CC_RST = 3'b100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  d_stat,
  input  logic [3:0]  d_icode,
  input  logic [3:0]  d_ifun,
  input  logic [63:0] d_valC,
  input  logic [63:0] d_valA,
  input  logic [63:0] d_valB,
  input  logic [3:0]  d_dstE,
  input  logic [3:0]  d_dstM,
  input  logic [3:0]  d_srcA,
  input  logic        e_bubble,
  input  logic        m_bubble,
  input  logic        m_exc,
  input  logic        w_exc,
  output logic [63:0] e_valE,
  output logic [3:0]  e_dstE,
  output logic        e_Cnd,
  output logic [2:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [2:0]  cc_out
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [3:0] I_NOP    = 4'h1;

  function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
    logic zf, sf, of;
    {zf, sf, of} = cc;
    case (fn)
      4'd0:    cond_eval = 1'b1;
      4'd1:    cond_eval = (sf ^ of) | zf;
      4'd2:    cond_eval = sf ^ of;
      4'd3:    cond_eval = zf;
      4'd4:    cond_eval = !zf;
      4'd5:    cond_eval = !(sf ^ of);
      4'd6:    cond_eval = !(sf ^ of) && !zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  logic        [2:0]  stat_p0;
  logic        [3:0]  icode_p0, ifun_p0, dste_p0, dstm_p0;
  logic        [63:0] valc_p0, vala_p0, valb_p0;
  logic signed [63:0] alu_a, alu_b, alu_out;
  logic        [1:0]  alu_ctl;
  logic               alu_of;
  logic        [2:0]  cc_q;
  logic               cc_upd;

  // ---- D/E boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || e_bubble) begin
      stat_p0  <= STAT_AOK;
      icode_p0 <= I_NOP;
      ifun_p0  <= '0;
      valc_p0  <= '0;
      vala_p0  <= '0;
      valb_p0  <= '0;
      dste_p0  <= RNONE;
      dstm_p0  <= RNONE;
    end else begin
      stat_p0  <= d_stat;
      icode_p0 <= d_icode;
      ifun_p0  <= d_ifun;
      valc_p0  <= d_valC;
      vala_p0  <= d_valA;
      valb_p0  <= d_valB;
      dste_p0  <= d_dstE;
      dstm_p0  <= d_dstM;
    end
  end

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (icode_p0)
      4'h2, 4'h6:       alu_a = vala_p0;
      4'h3, 4'h4, 4'h5: alu_a = valc_p0;
      4'h8, 4'hA:       alu_a = -64'sd8;
      4'h9, 4'hB:       alu_a = 64'sd8;
      default:          alu_a = '0;
    endcase
    case (icode_p0)
      4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: alu_b = valb_p0;
      default:                                  alu_b = '0;
    endcase
  end

  assign alu_ctl = (icode_p0 == 4'h6) ? ifun_p0[1:0] : 2'b00;

  ALU u_alu (
    .in1     (alu_b),
    .in2     (alu_a),
    .control (alu_ctl),
    .out     (alu_out),
    .of      (alu_of)
  );

  assign e_valE = alu_out;
  assign e_Cnd  = cond_eval(ifun_p0, cc_q);
  assign e_dstE = (icode_p0 == 4'h2 && !e_Cnd) ? RNONE : dste_p0;
  assign cc_upd = (icode_p0 == 4'h6) && !m_exc && !w_exc && (stat_p0 == STAT_AOK);

  // Logical ops never report overflow, regardless of what the adder path computed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cc_q <= CC_RST;
    else if (cc_upd)
      cc_q <= {(alu_out == '0), alu_out[63], alu_of && !alu_ctl[1]};
  end

  // ---- E/M boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || m_bubble) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else begin
      M_stat  <= stat_p0;
      M_icode <= icode_p0;
      M_Cnd   <= e_Cnd;
      M_valE  <= alu_out;
      M_valA  <= vala_p0;
      M_dstE  <= e_dstE;
      M_dstM  <= dstm_p0;
    end
  end

  assign cc_out = cc_q;

endmodule
